// File: rtl/free_list_mgr.sv
// Shared packet-buffer block allocator: fills a free-index FIFO after reset, grants one block per
// accepted request, and reclaims freed blocks (flooded blocks only after their last release).
module free_list_mgr #(
    parameter int N      = 4,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_req_i,
    output logic              alloc_gnt_o,
    output logic [ADDR_W-1:0] alloc_block_idx_o,
    input  logic              free_req_i,
    input  logic [ADDR_W-1:0] free_block_idx_i,
    input  logic              flood_i,
    output logic              ready_o,
    output logic [ADDR_W:0]   free_count_o,
    output logic              dbl_free_o
);
    localparam int NUM_BLOCKS = 2 ** ADDR_W;
    localparam int CNT_W      = (N > 2) ? $clog2(N) : 1;

    // state   | meaning
    // ST_INIT | loading index k into FIFO slot k, requests ignored
    // ST_RUN  | serving allocations and frees until reset
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_fifo [NUM_BLOCKS];
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_count;
    logic [NUM_BLOCKS-1:0] r_alloc;
    logic [CNT_W-1:0]    r_flood_cnt [NUM_BLOCKS];
    logic                r_gnt;
    logic [ADDR_W-1:0]   r_gnt_idx;
    logic                r_dbl;

    logic              w_run;
    logic              w_init_last;
    logic [ADDR_W-1:0] w_head;
    logic              w_pop;
    logic              w_free_ok;
    logic              w_dbl;
    logic              w_flood_last;
    logic              w_push;
    logic              w_flood_inc;

    assign w_run        = (r_state == ST_RUN);
    assign w_init_last  = (r_state == ST_INIT) && (r_wr_ptr == ADDR_W'(NUM_BLOCKS - 1));
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_pop        = w_run && alloc_req_i && (r_count != '0);
    // A block popped this cycle still reads as unallocated, so freeing it counts as a double free.
    assign w_free_ok    = w_run && free_req_i && r_alloc[free_block_idx_i];
    assign w_dbl        = w_run && free_req_i && !r_alloc[free_block_idx_i];
    assign w_flood_last = (r_flood_cnt[free_block_idx_i] == CNT_W'(N - 2));
    assign w_push       = w_free_ok && (!flood_i || w_flood_last);
    assign w_flood_inc  = w_free_ok && flood_i && !w_flood_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (w_init_last) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_alloc   <= '0;
            r_gnt     <= 1'b0;
            r_gnt_idx <= '0;
            r_dbl     <= 1'b0;
            for (int k = 0; k < NUM_BLOCKS; k++) begin
                r_flood_cnt[k] <= '0;
            end
        end else begin
            r_gnt <= w_pop;
            r_dbl <= w_dbl;

            // During INIT the write pointer doubles as the index being loaded and wraps to 0.
            if (r_state == ST_INIT) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (w_init_last) r_count <= (ADDR_W + 1)'(NUM_BLOCKS);
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (ADDR_W + 1)'(1);
                    2'b01:   r_count <= r_count - (ADDR_W + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end

            if (w_pop) begin
                r_gnt_idx           <= w_head;
                r_rd_ptr            <= r_rd_ptr + ADDR_W'(1);
                r_alloc[w_head]     <= 1'b1;
                r_flood_cnt[w_head] <= '0;
            end

            if (w_push) begin
                r_alloc[free_block_idx_i]     <= 1'b0;
                r_flood_cnt[free_block_idx_i] <= '0;
            end else if (w_flood_inc) begin
                r_flood_cnt[free_block_idx_i] <= r_flood_cnt[free_block_idx_i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_fifo[r_wr_ptr] <= r_wr_ptr;
        end else if (w_push) begin
            r_fifo[r_wr_ptr] <= free_block_idx_i;
        end
    end

    assign alloc_gnt_o       = r_gnt;
    assign alloc_block_idx_o = r_gnt_idx;
    assign ready_o           = w_run;
    assign free_count_o      = r_count;
    assign dbl_free_o        = r_dbl;

endmodule

// File: tb/tb_free_list_mgr.sv
// Directed bench for free_list_mgr (8 blocks, 4 ports) with hand-computed expectations.
module tb_free_list_mgr;
    logic       clk;
    logic       rst;
    logic       alloc_req;
    logic       gnt;
    logic [2:0] gnt_idx;
    logic       free_req;
    logic [2:0] free_idx;
    logic       flood;
    logic       ready;
    logic [3:0] count;
    logic       dbl;

    int n_tests = 0;
    int n_fail  = 0;

    free_list_mgr #(.N(4), .ADDR_W(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_req_i       (alloc_req),
        .alloc_gnt_o       (gnt),
        .alloc_block_idx_o (gnt_idx),
        .free_req_i        (free_req),
        .free_block_idx_i  (free_idx),
        .flood_i           (flood),
        .ready_o           (ready),
        .free_count_o      (count),
        .dbl_free_o        (dbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_init();
        int n;
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        flood     = 1'b0;
        free_idx  = '0;
        tick();
        tick();
        rst = 1'b0;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check("init_len", n, 8);
        check("init_count", count, 8);
    endtask

    initial begin
        rst       = 1'b1;
        alloc_req = 1'b0;
        free_req  = 1'b0;
        flood     = 1'b0;
        free_idx  = '0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_idx", gnt_idx, 0);
        check("rst_ready", ready, 0);
        check("rst_count", count, 0);
        check("rst_dbl", dbl, 0);

        // three back-to-back allocations
        reset_init();
        alloc_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("burst_gnt", gnt, 1);
            check("burst_idx", gnt_idx, i);
            check("burst_count", count, 7 - i);
        end
        alloc_req = 1'b0;
        tick();
        check("burst_end_gnt", gnt, 0);
        check("burst_end_count", count, 5);

        // drain all 8, 9th dropped, free 5 and reallocate it
        reset_init();
        alloc_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("drain_gnt", gnt, 1);
            check("drain_idx", gnt_idx, i);
            check("drain_count", count, 7 - i);
        end
        tick();
        check("empty_gnt", gnt, 0);
        check("empty_count", count, 0);
        alloc_req = 1'b0;
        free_req  = 1'b1;
        free_idx  = 3'd5;
        tick();
        check("free5_count", count, 1);
        check("free5_dbl", dbl, 0);
        free_req  = 1'b0;
        alloc_req = 1'b1;
        tick();
        check("realloc_gnt", gnt, 1);
        check("realloc_idx", gnt_idx, 5);
        check("realloc_count", count, 0);
        alloc_req = 1'b0;
        tick();
        check("realloc_end_gnt", gnt, 0);

        // flooded block 0 needs three releases
        free_req = 1'b1;
        free_idx = 3'd0;
        flood    = 1'b1;
        tick();
        check("flood1_count", count, 0);
        check("flood1_dbl", dbl, 0);
        tick();
        check("flood2_count", count, 0);
        tick();
        check("flood3_count", count, 1);
        check("flood3_dbl", dbl, 0);
        free_req = 1'b0;
        flood    = 1'b0;
        tick();
        check("flood_hold_count", count, 1);

        // freeing the already released block 0
        free_req = 1'b1;
        free_idx = 3'd0;
        tick();
        check("refree_dbl", dbl, 1);
        check("refree_count", count, 1);
        free_req = 1'b0;
        tick();
        check("refree_dbl_end", dbl, 0);
        check("refree_count_end", count, 1);
        alloc_req = 1'b1;
        tick();
        check("flood_realloc_idx", gnt_idx, 0);
        check("flood_realloc_gnt", gnt, 1);
        alloc_req = 1'b0;

        // never-allocated free, then simultaneous alloc/free at count=1
        reset_init();
        free_req = 1'b1;
        free_idx = 3'd4;
        tick();
        check("never_dbl", dbl, 1);
        check("never_count", count, 8);
        free_req = 1'b0;
        tick();
        check("never_dbl_end", dbl, 0);
        check("never_count_end", count, 8);
        alloc_req = 1'b1;
        repeat (7) tick();
        check("pre_sim_idx", gnt_idx, 6);
        check("pre_sim_count", count, 1);
        free_req = 1'b1;
        free_idx = 3'd2;
        tick();
        check("sim_gnt", gnt, 1);
        check("sim_idx", gnt_idx, 7);
        check("sim_count", count, 1);
        check("sim_dbl", dbl, 0);
        free_req = 1'b0;
        tick();
        check("sim_next_idx", gnt_idx, 2);
        check("sim_next_count", count, 0);
        free_req = 1'b1;
        free_idx = 3'd3;
        tick();
        check("nobypass_gnt", gnt, 0);
        check("nobypass_count", count, 1);
        free_req = 1'b0;
        tick();
        check("nobypass_idx", gnt_idx, 3);
        check("nobypass_gnt2", gnt, 1);
        check("nobypass_count2", count, 0);
        alloc_req = 1'b0;
        free_req  = 1'b1;
        free_idx  = 3'd1;
        tick();
        check("pop_free_pre_count", count, 1);
        alloc_req = 1'b1;
        tick();
        check("pop_free_gnt", gnt, 1);
        check("pop_free_idx", gnt_idx, 1);
        check("pop_free_dbl", dbl, 1);
        check("pop_free_count", count, 0);
        alloc_req = 1'b0;
        flood     = 1'b0;
        tick();
        check("pop_free_valid_count", count, 1);
        check("pop_free_valid_dbl", dbl, 0);
        free_req = 1'b0;

        // reset in the middle of an allocation burst
        reset_init();
        alloc_req = 1'b1;
        tick();
        tick();
        check("midrst_pre_idx", gnt_idx, 1);
        rst = 1'b1;
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_idx", gnt_idx, 0);
        check("midrst_ready", ready, 0);
        check("midrst_count", count, 0);
        check("midrst_dbl", dbl, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("midrst_init_gnt", gnt, 0);
        end
        check("midrst_ready_up", ready, 1);
        tick();
        check("midrst_first_gnt", gnt, 1);
        check("midrst_first_idx", gnt_idx, 0);
        check("midrst_first_count", count, 7);
        alloc_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/free_list_mgr.md
# free_list_mgr

Shared packet-buffer block allocator; the responder behind the switch arbiter's free-list request path. It hands one free block index per granted allocation to the port currently selected by the arbiter and reclaims blocks freed by the memory read controllers. Flooded blocks are reclaimed only after every egress port has released them. The block initialises its free FIFO after reset and flags illegal (double) frees.

## Interface
- N, switch_pkg::NUM_PORTS: switch ports; a flooded block needs N-1 frees.
- ADDR_W, mem_pkg::ADDR_W: block index width; NUM_BLOCKS = 2**ADDR_W.
- CNT_W, $clog2(N): per-block flood release counter width (localparam).

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- alloc_req_i  in  1  allocation request; every high cycle is a distinct request.
- alloc_gnt_o  out  1  registered grant, one cycle after an accepted request.
- alloc_block_idx_o  out  ADDR_W  granted index; valid only with alloc_gnt_o.
- free_req_i  in  1  release request for free_block_idx_i.
- free_block_idx_i  in  ADDR_W  block being released.
- flood_i  in  1  qualifies free_req_i: block was flooded to N-1 ports.
- ready_o  out  1  initialisation complete.
- free_count_o  out  ADDR_W+1  blocks currently in the free FIFO.
- dbl_free_o  out  1  one-cycle pulse: free of a block not currently allocated.

## Operation
- Storage: circular FIFO of NUM_BLOCKS x ADDR_W indices (rd_ptr, wr_ptr, count), allocated bitmap (NUM_BLOCKS bits), flood counter array (NUM_BLOCKS x CNT_W).
- FSM states: INIT, RUN.
  - INIT (entered on reset): writes index k into FIFO slot k, one per cycle, k = 0..NUM_BLOCKS-1. Requests are ignored (no grant, no dbl_free_o). After the last write: count = NUM_BLOCKS, wr_ptr wraps to 0, go to RUN, ready_o = 1.
  - RUN: stays there until reset.
- Allocation (RUN): alloc_req_i=1 and count>0 at edge t. The FIFO head is popped, its allocated bit set, its flood counter cleared. alloc_gnt_o=1 with the index during cycle t+1.
  - alloc_req_i=1 with count=0: dropped. No grant; the requester re-requests.
- Free (RUN), free_req_i=1:
  - Allocated bit clear: dbl_free_o pulses next cycle; no state change.
  - flood_i=0: final release. Push the index, clear the allocated bit, clear the counter.
  - flood_i=1 and counter < N-2: counter+1; no push.
  - flood_i=1 and counter = N-2: final release as above.
- Simultaneous alloc and free in one cycle:
  - Both are performed; count nets to unchanged.
  - There is no bypass: a push at t cannot satisfy a pop at t when count=0.
  - A free of the block being popped in that cycle is a double free (bit still clear).
- Pointers wrap modulo NUM_BLOCKS. count can never exceed NUM_BLOCKS because double frees are rejected.

## Timing
- Reset values: alloc_gnt_o=0, alloc_block_idx_o=0, ready_o=0, free_count_o=0, dbl_free_o=0; state=INIT; pointers, bitmap and counters=0.
- Reset asserted mid-operation aborts everything; the block restarts INIT. Outstanding allocations are lost by design.
- INIT lasts NUM_BLOCKS cycles. ready_o rises on the edge that performs the last write.
- Allocation latency: 1 cycle. Sustained throughput: one grant per cycle while count>0.
- free_count_o is registered and reflects all pushes and pops of edge t from cycle t+1.
- A block freed at edge t is allocatable by a request sampled at edge t+1.
- dbl_free_o: registered pulse in cycle t+1, exactly one cycle wide.

## Test plan
Bench parameters: ADDR_W=3 (8 blocks), N=4.
- Reset, wait for ready_o (8 cycles after release); then alloc_req_i high 3 cycles -> grants in 3 consecutive cycles with idx 0,1,2; free_count_o 8->5.
- Allocate all 8, then a 9th request -> 8 grants (idx 0..7), no 9th grant. Then free idx 5 (flood_i=0) and request next cycle -> grant idx 5; free_count_o goes 0->1->0.
- Allocate idx 0; free idx 0 with flood_i=1 three times -> no push after the 1st and 2nd frees; push after the 3rd; free_count_o +1 only then.
- Free idx 4 while never allocated -> dbl_free_o pulses exactly one cycle; free_count_o unchanged. Repeat the free of an already-released block -> same result.
- With count=1, alloc_req_i and free_req_i (flood_i=0, allocated idx 2) in the same cycle -> grant of the head index; free_count_o stays 1. After draining the rest, the next allocation returns idx 2.
- Assert rst mid-burst of allocations -> all outputs return to reset values immediately; re-INIT; the first allocation after ready_o returns idx 0.
